// File: rtl/trigger_buffer_reader_pkg.sv
// Shared constants and types for the oscilloscope trigger capture read path.
// The capture buffer geometry lives here so reader, interface and bench agree on it.
package osc_pkg;

    localparam int SAMPLE_W    = 8;
    localparam int TRIG_DEPTH  = 256;
    localparam int TRIG_ADDR_W = 8;

    // Entries in the sample skid FIFO between buffer read and plot pipeline.
    localparam int SKID_DEPTH  = 2;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        STREAM,
        RELEASE
    } rd_state_t;

endpackage

// File: rtl/trigger_buffer_reader_if.sv
// Buffer read port plus valid/ready sample stream of the trigger buffer reader.
// master = the reader; slave = the capture buffer and plot pipeline around it.
interface trigger_buffer_reader_if
    import osc_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int ADDR_W = TRIG_ADDR_W
) ();

    logic              buf_rd_en;
    logic [ADDR_W-1:0] buf_rd_addr;
    logic [DATA_W-1:0] buf_rd_data;

    logic [DATA_W-1:0] sample_data;
    logic [ADDR_W-1:0] sample_idx;
    logic              sample_last;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output buf_rd_en,
        output buf_rd_addr,
        input  buf_rd_data,
        output sample_data,
        output sample_idx,
        output sample_last,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  buf_rd_en,
        input  buf_rd_addr,
        output buf_rd_data,
        input  sample_data,
        input  sample_idx,
        input  sample_last,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/trigger_buffer_reader_sample_skid_fifo.sv
// Two-entry FIFO holding {index, sample} pairs returned from the capture buffer.
// Absorbs the one read still in flight when the plot pipeline stalls.
module sample_skid_fifo #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone says which slots hold live data.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/trigger_buffer_reader.sv
// Read side of the trigger capture buffer: waits for a finished capture, streams it on the
// next frame start as index-tagged valid/ready beats, then hands the buffer back to the trigger.
module trigger_buffer_reader
    import osc_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int DEPTH  = TRIG_DEPTH,
    parameter int ADDR_W = TRIG_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    capture_done,
    input  logic                    frame_start,
    trigger_buffer_reader_if.master bus,
    output logic                    rd_ack,
    output logic                    busy,
    output logic                    overrun
);

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rd_state_t         state_q, state_d;
    logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
    logic              inflight_q, inflight_d;
    logic              overrun_q, overrun_d;

    logic                     rd_issue;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [1:0]               fifo_count;
    logic [ADDR_W+DATA_W-1:0] fifo_wdata;
    logic [ADDR_W+DATA_W-1:0] fifo_head;
    logic [ADDR_W-1:0]        head_idx;
    logic [DATA_W-1:0]        head_data;
    logic [2:0]               occupancy;

    assign {head_idx, head_data} = fifo_head;

    // The returning read always belongs to the most recently issued address.
    assign fifo_push  = inflight_q;
    assign fifo_wdata = {ADDR_W'(issue_cnt_q - 1'b1), bus.buf_rd_data};
    assign fifo_pop   = !fifo_empty && bus.sample_ready;

    // A beat leaving the FIFO this cycle frees its slot for a read issued in the same cycle,
    // which keeps the stream at one beat per cycle while the pipeline accepts.
    assign occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(fifo_pop);

    sample_skid_fifo #(
        .W (ADDR_W + DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (fifo_wdata),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        overrun_d   = overrun_q || (capture_done && (state_q != IDLE));
        rd_issue    = 1'b0;
        rd_ack      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (capture_done) state_d = HELD;
            end
            HELD: begin
                if (frame_start) begin
                    state_d     = STREAM;
                    issue_cnt_d = '0;
                end
            end
            STREAM: begin
                rd_issue = (issue_cnt_q < DEPTH_C) && (occupancy < 3'd2);
                if (rd_issue) issue_cnt_d = issue_cnt_q + 1'b1;
                if (fifo_pop && (head_idx == LAST_IDX)) state_d = RELEASE;
            end
            RELEASE: begin
                rd_ack  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        inflight_d = rd_issue;
    end

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            inflight_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            inflight_q  <= inflight_d;
            overrun_q   <= overrun_d;
        end
    end

    no_fifo_overflow_a: assert property (@(posedge clk) disable iff (!rst) !(fifo_push && fifo_full));

    assign busy    = (state_q != IDLE);
    assign overrun = overrun_q;

    assign bus.buf_rd_en   = rd_issue;
    assign bus.buf_rd_addr = issue_cnt_q[ADDR_W-1:0];

    // Fields read as zero between beats, so the stream is quiet after reset.
    assign bus.sample_valid = !fifo_empty;
    assign bus.sample_data  = fifo_empty ? '0 : head_data;
    assign bus.sample_idx   = fifo_empty ? '0 : head_idx;
    assign bus.sample_last  = !fifo_empty && (head_idx == LAST_IDX);

endmodule

// File: tb/tb_trigger_buffer_reader.sv
// Self-checking bench for trigger_buffer_reader: control vector table, then full streams
// checked beat by beat against the expected capture contents and handshake timing.
module tb_trigger_buffer_reader;
    import osc_pkg::*;

    localparam int DEPTH   = TRIG_DEPTH;
    localparam int MAX_CYC = 3000;

    typedef struct packed {
        logic rst_n;
        logic cd;
        logic fs;
        logic busy;
        logic rden;
        logic ovr;
        logic ack;
    } vec_t;

    logic clk          = 1'b0;
    logic rst          = 1'b0;
    logic capture_done = 1'b0;
    logic frame_start  = 1'b0;
    logic ready        = 1'b0;
    logic rd_ack;
    logic busy;
    logic overrun;

    int checks   = 0;
    int failures = 0;

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [SAMPLE_W-1:0] rd_data_q = '0;
    vec_t                vecs [12];

    trigger_buffer_reader_if bus ();

    trigger_buffer_reader dut (
        .clk          (clk),
        .rst          (rst),
        .capture_done (capture_done),
        .frame_start  (frame_start),
        .bus          (bus),
        .rd_ack       (rd_ack),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Capture buffer model: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.buf_rd_en) rd_data_q <= mem[bus.buf_rd_addr];
    end

    assign bus.buf_rd_data  = rd_data_q;
    assign bus.sample_ready = ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic c, input logic f, input logic b,
                                input logic e, input logic o, input logic a);
        mk = '{r, c, f, b, e, o, a};
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_ack"},   32'(rd_ack), 0);
        check({tag, "_ovr"},   32'(overrun), 0);
        check({tag, "_rden"},  32'(bus.buf_rd_en), 0);
        check({tag, "_addr"},  32'(bus.buf_rd_addr), 0);
        check({tag, "_valid"}, 32'(bus.sample_valid), 0);
        check({tag, "_data"},  32'(bus.sample_data), 0);
        check({tag, "_idx"},   32'(bus.sample_idx), 0);
        check({tag, "_last"},  32'(bus.sample_last), 0);
    endtask

    task automatic idle_cycles(input int n, input logic exp_busy, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            capture_done = 1'b0;
            frame_start  = 1'b0;
            #1;
            check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
            check({tag, "_rden"}, 32'(bus.buf_rd_en), 0);
            check({tag, "_ack"},  32'(rd_ack), 0);
        end
    endtask

    task automatic pulse_capture();
        @(negedge clk);
        capture_done = 1'b1;
        frame_start  = 1'b0;
        #1;
        check("capture_from_idle_busy", 32'(busy), 0);
    endtask

    // mode 0: ready always 1; mode 1: random ready; mode 2: ready low for the first 20 stream cycles.
    // Cycle k=0 carries frame_start; the expected stream is mem[0..DEPTH-1] in index order.
    task automatic run_stream(input int mode, input int ovr_at, input int rst_at);
        int   exp_idx     = 0;
        int   issued      = 0;
        int   acks        = 0;
        int   first_valid = -1;
        int   last_hs     = -1;
        int   ack_k       = -1;
        int   stall_reads = 0;
        bit   done        = 1'b0;
        bit   aborted     = 1'b0;
        bit   ovr_sent    = 1'b0;
        bit   prev_stall  = 1'b0;
        bit   hs;
        logic [SAMPLE_W-1:0]    prev_data = '0;
        logic [TRIG_ADDR_W-1:0] prev_idx  = '0;
        logic                   prev_last = 1'b0;

        for (int k = 0; k < MAX_CYC && !done; k++) begin
            @(negedge clk);
            frame_start  = (k == 0);
            capture_done = 1'b0;
            if (ovr_at >= 0 && !ovr_sent && exp_idx == ovr_at) begin
                capture_done = 1'b1;
                ovr_sent     = 1'b1;
            end
            case (mode)
                0:       ready = 1'b1;
                1:       ready = 1'($urandom_range(0, 1));
                default: ready = (k > 20);
            endcase
            #1;
            hs = bus.sample_valid && ready;

            if (k == 0) begin
                check("fs_held_busy", 32'(busy), 1);
                check("fs_no_rden", 32'(bus.buf_rd_en), 0);
            end
            if (bus.buf_rd_en) begin
                check("rd_addr", 32'(bus.buf_rd_addr), issued);
                check("rd_window", 32'((issued - exp_idx - int'(hs)) < 2), 1);
                issued++;
                if (mode == 2 && k <= 20) stall_reads++;
            end
            if (bus.sample_valid) begin
                if (exp_idx >= DEPTH) begin
                    check("extra_valid", 32'(bus.sample_valid), 0);
                end else begin
                    check("beat_data", 32'(bus.sample_data), 32'(mem[exp_idx]));
                    check("beat_idx",  32'(bus.sample_idx), exp_idx);
                    check("beat_last", 32'(bus.sample_last), 32'(exp_idx == DEPTH - 1));
                end
                if (prev_stall)
                    check("hold_fields", 32'({bus.sample_data, bus.sample_idx, bus.sample_last}),
                          32'({prev_data, prev_idx, prev_last}));
            end else if (prev_stall) begin
                check("valid_dropped", 32'(bus.sample_valid), 1);
            end
            if (mode == 2 && k == 20) begin
                check("stall_head_valid", 32'(bus.sample_valid), 1);
                check("stall_head_data", 32'(bus.sample_data), 32'hFF);
            end
            if (first_valid < 0 && bus.sample_valid) first_valid = k;
            if (hs) begin
                exp_idx++;
                if (exp_idx == DEPTH) last_hs = k;
            end
            if (rd_ack) begin
                acks++;
                ack_k = k;
                check("ack_after_last", k, last_hs + 1);
            end else if (ack_k >= 0 && k == ack_k + 1) begin
                check("idle_after_ack", 32'(busy), 0);
                done = 1'b1;
            end
            if (rst_at >= 0 && exp_idx == rst_at) begin
                aborted = 1'b1;
                done    = 1'b1;
            end
            prev_stall = bus.sample_valid && !ready;
            prev_data  = bus.sample_data;
            prev_idx   = bus.sample_idx;
            prev_last  = bus.sample_last;
        end

        capture_done = 1'b0;
        frame_start  = 1'b0;
        if (aborted) begin
            check("abort_no_ack", acks, 0);
            return;
        end
        check("stream_finished", 32'(done), 1);
        check("beat_count", exp_idx, DEPTH);
        check("read_count", issued, DEPTH);
        check("ack_count", acks, 1);
        if (mode == 0) begin
            check("first_valid_cycle", first_valid, 3);
            check("last_beat_cycle", last_hs, 258);
        end
        if (mode == 2) check("reads_during_stall", stall_reads, 2);
        check("overrun_after_stream", 32'(overrun), 32'(ovr_at >= 0));
    endtask

    initial begin
        // Control table: expectations describe the state seen during the cycle the inputs are applied.
        vecs[0]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);

        rst   = 1'b0;
        ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_quiet("reset");

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rst          = vecs[i].rst_n;
            capture_done = vecs[i].cd;
            frame_start  = vecs[i].fs;
            #1;
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d_rden", i), 32'(bus.buf_rd_en), 32'(vecs[i].rden));
            check($sformatf("vec%0d_ovr", i),  32'(overrun), 32'(vecs[i].ovr));
            check($sformatf("vec%0d_ack", i),  32'(rd_ack), 32'(vecs[i].ack));
        end
        // Table leaves the reader HELD after a same-cycle capture/frame start: this frame start streams.
        run_stream(0, -1, -1);

        // Ramp with frame start ten cycles after the capture.
        pulse_capture();
        idle_cycles(9, 1'b1, "held_wait");
        run_stream(0, -1, -1);

        // Random contents under random backpressure.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
            idle_cycles(2, 1'b0, "idle_gap");
            pulse_capture();
            idle_cycles(1 + $urandom_range(0, 5), 1'b1, "held_rand");
            run_stream(1, -1, -1);
        end

        // Second capture mid-stream flags overrun without disturbing the stream.
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
        pulse_capture();
        idle_cycles(2, 1'b1, "held_ovr");
        run_stream(0, 100, -1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("overrun_sticky", 32'(overrun), 1);
            check("overrun_idle_ack", 32'(rd_ack), 0);
        end

        // Reset in the middle of a stream aborts it silently.
        pulse_capture();
        idle_cycles(1, 1'b1, "held_rst");
        run_stream(0, -1, 128);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_cycle_ack", 32'(rd_ack), 0);
        @(negedge clk);
        #1;
        check_quiet("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_quiet("after_reset");
        idle_cycles(3, 1'b0, "post_reset");
        pulse_capture();
        idle_cycles(3, 1'b1, "held_restart");
        run_stream(0, -1, -1);

        // Descending pattern with the pipeline stalled at stream start.
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'hFF - i);
        idle_cycles(2, 1'b0, "idle_pat");
        pulse_capture();
        idle_cycles(2, 1'b1, "held_pat");
        run_stream(2, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary in time");
        $fatal(1, "watchdog expired");
    end

endmodule
